eth_frame_parser: RTL and testbench

//  Consumes the byte stream from the pcap replay parser (one byte per valid cycle) and splits

---
 rtl/eth_frame_parser.sv | 222 ++++++++++++++++++++++
 tb/tb_eth_frame_parser.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_parser.sv
// eth_frame_parser: splits a replayed packet byte stream into Ethernet II header fields
// (one-cycle strobe) and a header-stripped payload byte stream with per-packet end strobes.
// Optional 802.1Q single-tag parsing (vlan_present/vlan_id ports) is enabled by defining
// the macro ETH_VLAN_EN; the default build reports 0x8100 as a plain ethertype.
module eth_frame_parser #(
   parameter int unsigned MAX_FRAME = 1518,
   parameter int unsigned OFS_W     = 11
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic [7:0]       in_pktcount,
   input  logic             in_available,
   output logic             hdr_valid,
   output logic [47:0]      eth_dst,
   output logic [47:0]      eth_src,
   output logic [15:0]      ethertype,
`ifdef ETH_VLAN_EN
   output logic             vlan_present,
   output logic [11:0]      vlan_id,
`endif
   output logic             pl_valid,
   output logic [7:0]       pl_data,
   output logic [OFS_W-1:0] pl_offset,
   output logic             eop,
   output logic             runt,
   output logic             oversize
);

   localparam logic [OFS_W-1:0] MaxOfs = OFS_W'(MAX_FRAME);

   typedef enum logic [2:0] {
      StIdle,
      StDst,
      StSrc,
      StType,
      StPayload
`ifdef ETH_VLAN_EN
      , StVlan
`endif
   } state_t;

   state_t           r_state;
   logic [7:0]       r_last_pc;
   logic             r_avail_q;
   logic [OFS_W-1:0] r_cnt;      // bytes accepted for the open packet, saturating
   logic [OFS_W-1:0] r_pl_cnt;   // next payload offset, saturating
   logic [103:0]     r_hdr;      // header bytes 0..12, first byte in the top lane
`ifdef ETH_VLAN_EN
   logic [11:0]      r_vid;
   logic [7:0]       r_inner_hi;
`endif

   logic             w_sop;
   logic             w_fall;
   logic             w_take;
   logic             w_hdr_shift;
   logic [OFS_W-1:0] w_cnt_inc;
   logic [OFS_W-1:0] w_pl_inc;
   logic [111:0]     w_hdr_sh;
   state_t           w_nxt_state;
   logic             w_hdr_done;
   logic [47:0]      w_dst;
   logic [47:0]      w_src;
   logic [15:0]      w_type;
`ifdef ETH_VLAN_EN
   logic             w_vp;
   logic [11:0]      w_vid;
`endif

   // Input qualification: packet start, end-of-packet edge and bytes belonging to the open packet.
   always_comb begin
      w_sop       = in_valid && (in_pktcount != r_last_pc);
      w_fall      = r_avail_q && !in_available;
      // Bytes seen in IDLE without a pktcount change are a mid-packet join and are dropped.
      w_take      = in_valid && !w_sop && (r_state != StIdle);
      w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + OFS_W'(1);
      w_pl_inc    = (r_pl_cnt == '1) ? r_pl_cnt : r_pl_cnt + OFS_W'(1);
      w_hdr_sh    = {r_hdr, in_data};
      // Byte 13 is never shifted in, so r_hdr still holds dst/src if a VLAN tag follows.
      w_hdr_shift = (r_state == StDst) || (r_state == StSrc) ||
                    ((r_state == StType) && (r_cnt == OFS_W'(12)));
   end

   // Header walk: next state for the byte taken this cycle and the fields it completes.
   always_comb begin
      w_nxt_state = r_state;
      w_hdr_done  = 1'b0;
      w_dst       = w_hdr_sh[111:64];
      w_src       = w_hdr_sh[63:16];
      w_type      = w_hdr_sh[15:0];
`ifdef ETH_VLAN_EN
      w_vp        = 1'b0;
      w_vid       = 12'h000;
`endif
      if (w_take) begin
         unique case (r_state)
            StDst: begin
               if (r_cnt == OFS_W'(5)) w_nxt_state = StSrc;
            end
            StSrc: begin
               if (r_cnt == OFS_W'(11)) w_nxt_state = StType;
            end
            StType: begin
               if (r_cnt == OFS_W'(13)) begin
`ifdef ETH_VLAN_EN
                  if (w_hdr_sh[15:0] == 16'h8100) begin
                     w_nxt_state = StVlan;
                  end else begin
                     w_nxt_state = StPayload;
                     w_hdr_done  = 1'b1;
                  end
`else
                  w_nxt_state = StPayload;
                  w_hdr_done  = 1'b1;
`endif
               end
            end
`ifdef ETH_VLAN_EN
            StVlan: begin
               if (r_cnt == OFS_W'(17)) begin
                  w_nxt_state = StPayload;
                  w_hdr_done  = 1'b1;
                  w_dst       = r_hdr[103:56];
                  w_src       = r_hdr[55:8];
                  w_type      = {r_inner_hi, in_data};
                  w_vp        = 1'b1;
                  w_vid       = r_vid;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Packet FSM with registered header, payload and end-of-packet outputs.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state    <= StIdle;
         r_last_pc  <= 8'h00;
         r_avail_q  <= 1'b0;
         r_cnt      <= '0;
         r_pl_cnt   <= '0;
         r_hdr      <= '0;
         hdr_valid  <= 1'b0;
         eth_dst    <= '0;
         eth_src    <= '0;
         ethertype  <= '0;
         pl_valid   <= 1'b0;
         pl_data    <= '0;
         pl_offset  <= '0;
         eop        <= 1'b0;
         runt       <= 1'b0;
         oversize   <= 1'b0;
`ifdef ETH_VLAN_EN
         r_vid        <= '0;
         r_inner_hi   <= '0;
         vlan_present <= 1'b0;
         vlan_id      <= '0;
`endif
      end else begin
         r_avail_q <= in_available;
         hdr_valid <= 1'b0;
         pl_valid  <= 1'b0;
         eop       <= 1'b0;
         runt      <= 1'b0;
         if (w_sop) begin
            // Close any open packet; a falling edge in this same cycle is taken as its end.
            if (r_state != StIdle) begin
               eop  <= 1'b1;
               runt <= (r_state != StPayload);
            end
            r_last_pc <= in_pktcount;
            r_cnt     <= OFS_W'(1);
            r_hdr     <= w_hdr_sh[103:0];
            oversize  <= 1'b0;
            r_state   <= StDst;
         end else begin
            if (w_take) begin
               r_cnt <= w_cnt_inc;
               if (w_cnt_inc > MaxOfs) oversize <= 1'b1;
               if (w_hdr_shift) r_hdr <= w_hdr_sh[103:0];
`ifdef ETH_VLAN_EN
               if (r_state == StVlan) begin
                  if (r_cnt == OFS_W'(14)) r_vid[11:8] <= in_data[3:0];
                  if (r_cnt == OFS_W'(15)) r_vid[7:0]  <= in_data;
                  if (r_cnt == OFS_W'(16)) r_inner_hi  <= in_data;
               end
`endif
               if (r_state == StPayload) begin
                  pl_valid  <= 1'b1;
                  pl_data   <= in_data;
                  pl_offset <= r_pl_cnt;
                  r_pl_cnt  <= w_pl_inc;
               end
            end
            if (w_hdr_done) begin
               hdr_valid <= 1'b1;
               eth_dst   <= w_dst;
               eth_src   <= w_src;
               ethertype <= w_type;
               r_pl_cnt  <= '0;
`ifdef ETH_VLAN_EN
               vlan_present <= w_vp;
               vlan_id      <= w_vid;
`endif
            end
            // End of packet is judged on the state after this cycle's byte.
            if (w_fall && (w_nxt_state != StIdle)) begin
               eop     <= 1'b1;
               runt    <= (w_nxt_state != StPayload);
               r_state <= StIdle;
            end else begin
               r_state <= w_nxt_state;
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_frame_parser.sv
// tb_eth_frame_parser: directed frames against a packet-level expectation model of
// eth_frame_parser (header fields, payload queue, end-of-packet/runt queue, oversize).
module tb_eth_frame_parser;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [7:0]  in_pktcount;
   logic        in_available;
   logic        hdr_valid;
   logic [47:0] eth_dst;
   logic [47:0] eth_src;
   logic [15:0] ethertype;
`ifdef ETH_VLAN_EN
   logic        vlan_present;
   logic [11:0] vlan_id;
`endif
   logic        pl_valid;
   logic [7:0]  pl_data;
   logic [10:0] pl_offset;
   logic        eop;
   logic        runt;
   logic        oversize;

   eth_frame_parser #(.MAX_FRAME(1518), .OFS_W(11)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_pktcount  (in_pktcount),
      .in_available (in_available),
      .hdr_valid    (hdr_valid),
      .eth_dst      (eth_dst),
      .eth_src      (eth_src),
      .ethertype    (ethertype),
`ifdef ETH_VLAN_EN
      .vlan_present (vlan_present),
      .vlan_id      (vlan_id),
`endif
      .pl_valid     (pl_valid),
      .pl_data      (pl_data),
      .pl_offset    (pl_offset),
      .eop          (eop),
      .runt         (runt),
      .oversize     (oversize)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct packed {
      logic [47:0] d;
      logic [47:0] s;
      logic [15:0] t;
      logic        vp;
      logic [11:0] vid;
   } hdr_t;

   typedef struct packed {
      logic [7:0]  d;
      logic [10:0] o;
      logic        ovs;
   } pl_t;

   logic [7:0] pkt[$];
   hdr_t       exp_hdr[$];
   pl_t        exp_pl[$];
   logic       exp_eop[$];

   int n_cmp = 0;
   int n_err = 0;
   int n_hdr, n_pl, n_eop, n_runt, first_ovs;
   logic [10:0] last_pl_off;
   logic [7:0]  last_pl_data;
   logic [7:0]  pl_first[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_stats();
      n_hdr = 0; n_pl = 0; n_eop = 0; n_runt = 0; first_ovs = -1;
      last_pl_off = '0; last_pl_data = '0; pl_first[0] = '0; pl_first[1] = '0;
   endtask

   // Expected outputs for the whole packet in pkt, derived from the frame layout.
   task automatic model_expect(input bit ends);
      int hl;
      hdr_t h;
      pl_t p;
      hl = 14;
      h = '0;
      if (pkt.size() >= 14) begin
         for (int k = 0; k < 6; k++) begin
            h.d = {h.d[39:0], pkt[k]};
            h.s = {h.s[39:0], pkt[k+6]};
         end
         h.t = {pkt[12], pkt[13]};
`ifdef ETH_VLAN_EN
         if (h.t == 16'h8100) begin
            hl = 18;
            if (pkt.size() >= 18) begin
               h.vp  = 1'b1;
               h.vid = {pkt[14][3:0], pkt[15]};
               h.t   = {pkt[16], pkt[17]};
            end
         end
`endif
         if (pkt.size() >= hl) exp_hdr.push_back(h);
      end
      for (int i = hl; i < pkt.size(); i++) begin
         p.d   = pkt[i];
         p.o   = (i - hl > 2047) ? 11'h7FF : 11'(i - hl);
         p.ovs = (i + 1 > 1518);
         exp_pl.push_back(p);
      end
      if (ends) exp_eop.push_back(pkt.size() < hl);
   endtask

   task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                        input int npl, input logic [7:0] base, input logic [7:0] stp);
      pkt.delete();
      for (int k = 5; k >= 0; k--) pkt.push_back(d[k*8 +: 8]);
      for (int k = 5; k >= 0; k--) pkt.push_back(s[k*8 +: 8]);
      pkt.push_back(t[15:8]);
      pkt.push_back(t[7:0]);
      for (int i = 0; i < npl; i++) pkt.push_back(base + 8'(i) * stp);
   endtask

   // Every cycle: check what the DUT produced against the model, then drive the next inputs.
   task automatic compare_outputs();
      hdr_t h;
      pl_t p;
      logic r;
      if (hdr_valid === 1'b1) begin
         n_hdr++;
         chk("hdr_expected", 64'(exp_hdr.size() > 0), 64'd1);
         if (exp_hdr.size() > 0) begin
            h = exp_hdr.pop_front();
            chk("eth_dst", 64'(eth_dst), 64'(h.d));
            chk("eth_src", 64'(eth_src), 64'(h.s));
            chk("ethertype", 64'(ethertype), 64'(h.t));
`ifdef ETH_VLAN_EN
            chk("vlan_present", 64'(vlan_present), 64'(h.vp));
            chk("vlan_id", 64'(vlan_id), 64'(h.vid));
`endif
         end
      end
      if (pl_valid === 1'b1) begin
         if (n_pl < 2) pl_first[n_pl] = pl_data;
         n_pl++;
         last_pl_off  = pl_offset;
         last_pl_data = pl_data;
         if (oversize === 1'b1 && first_ovs < 0) first_ovs = int'(pl_offset);
         chk("pl_expected", 64'(exp_pl.size() > 0), 64'd1);
         if (exp_pl.size() > 0) begin
            p = exp_pl.pop_front();
            chk("pl_data", 64'(pl_data), 64'(p.d));
            chk("pl_offset", 64'(pl_offset), 64'(p.o));
            chk("pl_oversize", 64'(oversize), 64'(p.ovs));
         end
      end
      if (eop === 1'b1) begin
         n_eop++;
         if (runt === 1'b1) n_runt++;
         chk("eop_expected", 64'(exp_eop.size() > 0), 64'd1);
         if (exp_eop.size() > 0) begin
            r = exp_eop.pop_front();
            chk("runt", 64'(runt), 64'(r));
         end
      end else begin
         chk("runt_alone", 64'(runt), 64'd0);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic [7:0] pc, input logic av);
      @(negedge CLOCK);
      compare_outputs();
      in_valid     = v;
      in_data      = d;
      in_pktcount  = pc;
      in_available = av;
   endtask

   task automatic drive_pkt(input logic [7:0] pc, input bit gap, input bit fall);
      for (int i = 0; i < pkt.size(); i++) begin
         step(1'b1, pkt[i], pc, 1'b1);
         if (gap) step(1'b0, 8'h00, pc, 1'b1);
      end
      if (fall) step(1'b0, 8'h00, pc, 1'b0);
   endtask

   task automatic drain(input logic [7:0] pc, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, pc, 1'b0);
   endtask

   task automatic check_std_frame(input string tag);
      chk({tag, "_dst"}, 64'(eth_dst), 64'hFFFF_FFFF_FFFF);
      chk({tag, "_src"}, 64'(eth_src), 64'h0011_2233_4455);
      chk({tag, "_type"}, 64'(ethertype), 64'h0800);
      chk({tag, "_nhdr"}, 64'(n_hdr), 64'd1);
      chk({tag, "_npl"}, 64'(n_pl), 64'd46);
      chk({tag, "_last_off"}, 64'(last_pl_off), 64'd45);
      chk({tag, "_last_data"}, 64'(last_pl_data), 64'h2D);
      chk({tag, "_neop"}, 64'(n_eop), 64'd1);
      chk({tag, "_nrunt"}, 64'(n_runt), 64'd0);
   endtask

   initial begin
      RESET = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_pktcount = 8'h00; in_available = 1'b0;
      repeat (3) @(negedge CLOCK);
      chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      chk("rst_pl_valid", 64'(pl_valid), 64'd0);
      chk("rst_eop", 64'(eop), 64'd0);
      chk("rst_runt", 64'(runt), 64'd0);
      chk("rst_oversize", 64'(oversize), 64'd0);
      chk("rst_eth_dst", 64'(eth_dst), 64'd0);
      chk("rst_ethertype", 64'(ethertype), 64'd0);
      chk("rst_pl_offset", 64'(pl_offset), 64'd0);
      RESET = 1'b0;
      drain(8'h00, 2);

      // 60-byte frame, contiguous.
      clr_stats();
      build(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 8'h00, 8'h01);
      model_expect(1'b1);
      chk("model_dst", 64'(exp_hdr[exp_hdr.size()-1].d), 64'hFFFF_FFFF_FFFF);
      chk("model_npl", 64'(exp_pl.size()), 64'd46);
      drive_pkt(8'h01, 1'b0, 1'b1);
      drain(8'h01, 3);
      check_std_frame("contig");

      // Same frame with in_valid toggling every other cycle.
      clr_stats();
      model_expect(1'b1);
      drive_pkt(8'h02, 1'b1, 1'b1);
      drain(8'h02, 3);
      check_std_frame("gapped");

      // 10-byte runt.
      clr_stats();
      build(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0800, 0, 8'h00, 8'h00);
      pkt = pkt[0:9];
      model_expect(1'b1);
      drive_pkt(8'h03, 1'b0, 1'b1);
      drain(8'h03, 3);
      chk("runt_neop", 64'(n_eop), 64'd1);
      chk("runt_nrunt", 64'(n_runt), 64'd1);
      chk("runt_nhdr", 64'(n_hdr), 64'd0);

      // Stray byte in IDLE with unchanged pktcount is ignored.
      clr_stats();
      step(1'b1, 8'h55, 8'h03, 1'b0);
      drain(8'h03, 3);
      chk("stray_npl", 64'(n_pl), 64'd0);
      chk("stray_neop", 64'(n_eop), 64'd0);

      // Back-to-back packets, pktcount 4 -> 5 with no idle cycle.
      clr_stats();
      build(48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h86DD, 16, 8'hA0, 8'h01);
      model_expect(1'b1);
      drive_pkt(8'h04, 1'b0, 1'b0);
      build(48'h2021_2223_2425, 48'h3031_3233_3435, 16'h0806, 6, 8'h50, 8'h01);
      model_expect(1'b1);
      drive_pkt(8'h05, 1'b0, 1'b1);
      drain(8'h05, 3);
      chk("b2b_nhdr", 64'(n_hdr), 64'd2);
      chk("b2b_neop", 64'(n_eop), 64'd2);
      chk("b2b_npl", 64'(n_pl), 64'd22);
      chk("b2b_last_data", 64'(last_pl_data), 64'h55);
      chk("b2b_type", 64'(ethertype), 64'h0806);

      // 802.1Q tagged frame: TCI 0x0064, inner type 0x0800.
      clr_stats();
      build(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h8100, 0, 8'h00, 8'h00);
      pkt.push_back(8'h00); pkt.push_back(8'h64); pkt.push_back(8'h08); pkt.push_back(8'h00);
      for (int i = 0; i < 10; i++) pkt.push_back(8'hC0 + 8'(i));
      model_expect(1'b1);
      drive_pkt(8'h06, 1'b0, 1'b1);
      drain(8'h06, 3);
`ifdef ETH_VLAN_EN
      chk("vlan_type", 64'(ethertype), 64'h0800);
      chk("vlan_id_lit", 64'(vlan_id), 64'd100);
      chk("vlan_present_lit", 64'(vlan_present), 64'd1);
      chk("vlan_pl0", 64'(pl_first[0]), 64'hC0);
      chk("vlan_npl", 64'(n_pl), 64'd10);
`else
      chk("tag_type", 64'(ethertype), 64'h8100);
      chk("tag_pl0", 64'(pl_first[0]), 64'h00);
      chk("tag_pl1", 64'(pl_first[1]), 64'h64);
      chk("tag_npl", 64'(n_pl), 64'd14);
`endif

      // Reset during byte 8, then a 1600-byte frame.
      clr_stats();
      build(48'h0200_0000_0007, 48'h0200_0000_0008, 16'h0800, 0, 8'h00, 8'h00);
      for (int i = 0; i < 9; i++) step(1'b1, pkt[i], 8'h07, 1'b1);
      step(1'b0, 8'h00, 8'h07, 1'b0);
      RESET = 1'b1;
      step(1'b0, 8'h00, 8'h07, 1'b0);
      RESET = 1'b0;
      drain(8'h07, 2);
      chk("abort_neop", 64'(n_eop), 64'd0);
      build(48'hAABB_CCDD_EEFF, 48'h0011_2233_4455, 16'h0800, 1586, 8'h00, 8'h07);
      model_expect(1'b1);
      drive_pkt(8'h08, 1'b0, 1'b1);
      drain(8'h08, 3);
      chk("big_oversize_sticky", 64'(oversize), 64'd1);
      chk("big_first_ovs_off", 64'(first_ovs), 64'd1504);
      chk("big_npl", 64'(n_pl), 64'd1586);
      chk("big_neop", 64'(n_eop), 64'd1);
      chk("big_nrunt", 64'(n_runt), 64'd0);

      chk("left_hdr", 64'(exp_hdr.size()), 64'd0);
      chk("left_pl", 64'(exp_pl.size()), 64'd0);
      chk("left_eop", 64'(exp_eop.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
